// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared register-file constants, write-request type and the
//                zero-register predicate used by the write-back front end.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
    localparam int DATA_W     = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] address;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == ZERO_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : In-order load queue holding {address, data} entries; exposes
//                every slot's address and valid bit for pending decode.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [AW-1:0]           push_address,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [AW-1:0]           head_address,
    output logic [W-1:0]            head_data,
    output logic [DEPTH*AW-1:0]     entry_address,
    output logic [DEPTH-1:0]        entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // Pop clears before push sets, so a wrap onto the same slot stays valid.
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            addr_d[wr_ptr_q]  = push_address;
            data_d[wr_ptr_q]  = push_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            assign entry_address[g*AW +: AW] = addr_q[g];
        end
    endgenerate

    assign entry_valid  = valid_q;
    assign count        = count_q;
    assign head_address = addr_q[rd_ptr_q];
    assign head_data    = data_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Merges ALU and load write requests onto the register file's
//                single write port; loads pass through an in-order queue.
//                Define REGFILE_WB_BYPASS_EN to let a load skip an empty queue.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [4:0]             alu_address,
    input  logic [N-1:0]           alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [4:0]             mem_address,
    input  logic [N-1:0]           mem_data,
    output logic                   wb_write,
    output logic [4:0]             wb_address,
    output logic [N-1:0]           wb_data,
    output logic [31:0]            pending,
    output logic [$clog2(DEPTH):0] queue_count
);

    logic                        q_full;
    logic                        q_empty;
    logic [REG_ADDR_W-1:0]       q_head_address;
    logic [N-1:0]                q_head_data;
    logic [DEPTH*REG_ADDR_W-1:0] q_entry_address;
    logic [DEPTH-1:0]            q_entry_valid;
    logic [REG_COUNT-1:0]        pending_vec;

    logic alu_take;
    logic mem_take;
    logic bypass;
    logic q_push;
    logic q_pop;

    logic                  wb_write_q, wb_write_d;
    logic [REG_ADDR_W-1:0] wb_address_q, wb_address_d;
    logic [N-1:0]          wb_data_q, wb_data_d;

    wb_fifo #(
        .W     (N),
        .DEPTH (DEPTH),
        .AW    (REG_ADDR_W)
    ) u_fifo (
        .clock         (clock),
        .reset         (reset),
        .push          (q_push),
        .push_address  (mem_address),
        .push_data     (mem_data),
        .pop           (q_pop),
        .full          (q_full),
        .empty         (q_empty),
        .count         (queue_count),
        .head_address  (q_head_address),
        .head_data     (q_head_data),
        .entry_address (q_entry_address),
        .entry_valid   (q_entry_valid)
    );

    always_comb begin
        pending_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_entry_valid[i]) begin
                pending_vec[q_entry_address[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
            end
        end
    end

    // Blocking on pending keeps an ALU write from overtaking an older queued load.
    assign alu_ready = ~q_full & ~pending_vec[alu_address];
    assign mem_ready = ~q_full;

    // Zero-register requests handshake but are dropped here.
    assign alu_take = alu_valid & alu_ready & ~is_zero_reg(alu_address);
    assign mem_take = mem_valid & mem_ready & ~is_zero_reg(mem_address);

`ifdef REGFILE_WB_BYPASS_EN
    assign bypass = mem_take & q_empty & ~alu_take;
`else
    assign bypass = 1'b0;
`endif

    assign q_push = mem_take & ~bypass;
    assign q_pop  = ~alu_take & ~q_empty;

    always_comb begin
        wb_write_d   = 1'b0;
        wb_address_d = wb_address_q;
        wb_data_d    = wb_data_q;
        if (alu_take) begin
            wb_write_d   = 1'b1;
            wb_address_d = alu_address;
            wb_data_d    = alu_data;
        end else if (bypass) begin
            wb_write_d   = 1'b1;
            wb_address_d = mem_address;
            wb_data_d    = mem_data;
        end else if (!q_empty) begin
            wb_write_d   = 1'b1;
            wb_address_d = q_head_address;
            wb_data_d    = q_head_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_write_q   <= 1'b0;
            wb_address_q <= '0;
            wb_data_q    <= '0;
        end else begin
            wb_write_q   <= wb_write_d;
            wb_address_q <= wb_address_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign wb_write   = wb_write_q;
    assign wb_address = wb_address_q;
    assign wb_data    = wb_data_q;
    assign pending    = pending_vec;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback
//  Description : Directed self-checking bench for regfile_writeback with a
//                behavioural register file fed from the write port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_writeback;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_address;
    logic [63:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_address;
    logic [63:0] mem_data;
    logic        wb_write;
    logic [4:0]  wb_address;
    logic [63:0] wb_data;
    logic [31:0] pending;
    logic [2:0]  queue_count;

    logic [63:0] rf [32];
    int          total;
    int          bad;

    regfile_writeback #(
        .N     (64),
        .DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_address (alu_address),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .wb_write    (wb_write),
        .wb_address  (wb_address),
        .wb_data     (wb_data),
        .pending     (pending),
        .queue_count (queue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (wb_write) rf[wb_address] <= wb_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rf[i] = 64'h0;
        reset = 1'b1; alu_valid = 1'b0; alu_address = '0; alu_data = '0;
        mem_valid = 1'b0; mem_address = '0; mem_data = '0;

        repeat (2) @(negedge clock);
        check_eq("rst_wb_write", wb_write, 0);
        check_eq("rst_wb_addr", wb_address, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_count", queue_count, 0);
        check_eq("rst_pending", pending, 0);
        reset = 1'b0;
        #1;
        check_eq("idle_mem_ready", mem_ready, 1);
        check_eq("idle_alu_ready", alu_ready, 1);

        // ALU write r5
        alu_valid = 1'b1; alu_address = 5'd5; alu_data = 64'h1234;
        @(negedge clock);
        alu_valid = 1'b0;
        check_eq("alu_wb_write", wb_write, 1);
        check_eq("alu_wb_addr", wb_address, 5);
        check_eq("alu_wb_data", wb_data, 64'h1234);
        @(negedge clock);
        check_eq("alu_one_cycle", wb_write, 0);
        check_eq("rf_r5", rf[5], 64'h1234);

        // Loads r1..r4 under a sustained ALU stream to r9
        alu_valid = 1'b1; alu_address = 5'd9; mem_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_data = 64'h900 + 64'(i);
            mem_address = 5'(i);
            mem_data = 64'h100 + 64'(i);
            @(negedge clock);
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check_eq("full_mem_ready", mem_ready, 0);
        check_eq("full_alu_ready", alu_ready, 0);
        check_eq("full_count", queue_count, 4);
        check_eq("full_pending", pending, 32'h0000_001E);
        check_eq("stream_last_alu", wb_data, 64'h904);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            check_eq("drain_write", wb_write, 1);
            check_eq("drain_addr", wb_address, 64'(i));
            check_eq("drain_data", wb_data, 64'h100 + 64'(i));
        end
        check_eq("drained_count", queue_count, 0);
        alu_valid = 1'b1; alu_address = 5'd9; alu_data = 64'h999;
        @(negedge clock);
        alu_valid = 1'b0;
        check_eq("r9_addr", wb_address, 9);
        check_eq("r9_data", wb_data, 64'h999);
        @(negedge clock);
        check_eq("rf_r9", rf[9], 64'h999);
        check_eq("rf_r4", rf[4], 64'h104);

        // WAW: queued load r7 blocks ALU r7
        alu_valid = 1'b1; alu_address = 5'd8; alu_data = 64'h88;
        mem_valid = 1'b1; mem_address = 5'd7; mem_data = 64'h77;
        @(negedge clock);
        mem_valid = 1'b0; alu_address = 5'd7; alu_data = 64'h70;
        #1;
        check_eq("waw_pending7", pending[7], 1);
        check_eq("waw_alu_blocked", alu_ready, 0);
        check_eq("waw_r8_addr", wb_address, 8);
        @(negedge clock);
        check_eq("waw_load_addr", wb_address, 7);
        check_eq("waw_load_data", wb_data, 64'h77);
        check_eq("waw_alu_ready", alu_ready, 1);
        @(negedge clock);
        alu_valid = 1'b0;
        check_eq("waw_alu_write", wb_write, 1);
        check_eq("waw_alu_data", wb_data, 64'h70);
        @(negedge clock);
        check_eq("rf_r7", rf[7], 64'h70);

        // Zero register
        alu_valid = 1'b1; alu_address = 5'd31; alu_data = 64'hDEAD;
        mem_valid = 1'b1; mem_address = 5'd31; mem_data = 64'hBEEF;
        #1;
        check_eq("r31_alu_ready", alu_ready, 1);
        check_eq("r31_mem_ready", mem_ready, 1);
        @(negedge clock);
        alu_valid = 1'b0; mem_valid = 1'b0;
        check_eq("r31_no_write", wb_write, 0);
        check_eq("r31_pending", pending, 0);
        check_eq("r31_count", queue_count, 0);
        @(negedge clock);
        check_eq("r31_no_write2", wb_write, 0);

        // Same-cycle ALU and load to r3
        alu_valid = 1'b1; alu_address = 5'd3; alu_data = 64'hA;
        mem_valid = 1'b1; mem_address = 5'd3; mem_data = 64'hB;
        @(negedge clock);
        alu_valid = 1'b0; mem_valid = 1'b0;
        check_eq("same_first", wb_data, 64'hA);
        check_eq("same_count", queue_count, 1);
        @(negedge clock);
        check_eq("same_second_addr", wb_address, 3);
        check_eq("same_second", wb_data, 64'hB);
        @(negedge clock);
        check_eq("rf_r3", rf[3], 64'hB);

        // Reset with three queued loads
        alu_valid = 1'b1; alu_address = 5'd10; mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_data = 64'hA0 + 64'(i);
            mem_address = 5'(11 + i);
            mem_data = 64'hB0 + 64'(i);
            @(negedge clock);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        check_eq("pre_rst_count", queue_count, 3);
        reset = 1'b1;
        #1;
        check_eq("arst_wb_write", wb_write, 0);
        check_eq("arst_wb_addr", wb_address, 0);
        check_eq("arst_wb_data", wb_data, 0);
        check_eq("arst_count", queue_count, 0);
        check_eq("arst_pending", pending, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("post_rst_quiet", wb_write, 0);
        end

        // Lone load latency
        mem_valid = 1'b1; mem_address = 5'd4; mem_data = 64'hC;
        @(negedge clock);
        mem_valid = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        check_eq("bypass_write", wb_write, 1);
        check_eq("bypass_addr", wb_address, 4);
        check_eq("bypass_data", wb_data, 64'hC);
        check_eq("bypass_pending", pending, 0);
`else
        check_eq("load_lat_quiet", wb_write, 0);
        check_eq("load_lat_count", queue_count, 1);
        check_eq("load_lat_pending", pending, 32'h10);
        @(negedge clock);
        check_eq("load_write", wb_write, 1);
        check_eq("load_addr", wb_address, 4);
        check_eq("load_data", wb_data, 64'hC);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the 32-entry register file. Accepts register writes from two producers (ALU result path, memory-load path) through valid/ready handshakes. Merges them onto the register file's single write port (`data_in`, `address`, `write`). Load writes go through a small in-order queue; a per-register pending vector lets issue logic stall on queued loads.

## Interface
Parameters:
- `N`, 64, data width; matches register width.
- `DEPTH`, 4, load-queue entries; power of two, ≥2.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `alu_valid` input 1: ALU write request.
- `alu_ready` output 1: ALU request accepted this cycle when high with `alu_valid`.
- `alu_address` input 5: destination register.
- `alu_data` input N: write data.
- `mem_valid` input 1: load write request.
- `mem_ready` output 1: load accepted into queue when high with `mem_valid`.
- `mem_address` input 5: destination register.
- `mem_data` input N: write data.
- `wb_write` output 1: drives register-file `write`.
- `wb_address` output 5: drives register-file `address`.
- `wb_data` output N: drives register-file `data_in`.
- `pending` output 32: bit i set while any valid queue entry targets register i.
- `queue_count` output log2(DEPTH)+1: number of valid queue entries.

## Operation
- Load queue: FIFO, in-order, `DEPTH` entries.
- `mem_ready = ~full`. No enqueue-on-full, even if the queue drains that cycle.
- `alu_ready = ~full & ~pending[alu_address]`. A full queue forces drain. A pending match prevents an ALU write overtaking an older queued load to the same register (WAW).
- Arbitration, one write per cycle: the ALU wins if `alu_valid & alu_ready`; otherwise the queue head issues if the queue is non-empty.
- Register 31 is hardwired zero:
  - Requests with address 31 complete their handshake normally.
  - They are discarded: not enqueued, not issued, never set `pending[31]`.
- ALU and load handshakes in the same cycle to the same register: the ALU write issues first and the load lands later. The load is the younger write, so the final value is the load data.
- `pending` and `queue_count` are combinational from queue state. `pending` updates the cycle after enqueue and clears the cycle after the entry is popped.

## Timing
- Reset values: `wb_write=0`, `wb_address=0`, `wb_data=0`, queue empty, `pending=0`, `queue_count=0`.
  - `mem_ready=1` and `alu_ready=1` while reset is deasserted and the queue is empty.
- Reset mid-operation: queued loads are lost. Producers must reissue.
- `wb_*` are registered. `wb_write` is high for exactly one cycle per issued write.
- ALU latency: handshake at edge k → `wb_write` high from edge k+1 to edge k+2.
- Load latency without bypass: enqueue at edge k → earliest issue visible after edge k+1.
- Throughput: one write per cycle total. A sustained ALU stream starves the queue until it fills, then the ALU stalls.
- Full plus simultaneous pop: `mem_ready` stays 0 that cycle and reasserts the next cycle.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - Applies when the queue is empty and no ALU write wins the cycle.
  - A handshaken load (address ≠ 31) bypasses the queue and issues directly, latency 1, `pending` never set.
- Not defined: every load is enqueued; minimum latency 2.

## Structure
- Shared package `regfile_pkg`: `REG_COUNT=32`, `REG_ADDR_W=5`, `ZERO_REG=5'd31`, `DATA_W=64`, and a packed write-request typedef {address, data}.
- Sub-module `wb_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count and exposure of all entries' address plus valid bits, used for the `pending` decode.
- Arbitration, zero-register filtering and output registers live in the top level.

## Test plan
- ALU write r5=0x1234 after reset → next cycle `wb_write=1`, `wb_address=5`, `wb_data=0x1234`. Register file r5 reads 0x1234 afterwards.
- Four loads r1..r4 back-to-back with `alu_valid` held, targeting r9 → queue fills; `mem_ready=0` and `alu_ready=0`. Queue drains r1..r4 in order, then r9 issues.
- Load to r7 queued, then ALU to r7 → `alu_ready=0` while `pending[7]=1`. ALU is accepted the cycle after the load issues; final r7 holds the ALU data.
- ALU to r31 and load to r31 → both handshakes complete; `wb_write` never asserts; `pending=0`.
- Same-cycle ALU r3=0xA and load r3=0xB with the queue empty → ALU issues first, load second; r3 ends 0xB.
- Reset asserted with 3 queued loads → outputs are immediately 0, `queue_count=0`, no further `wb_write`. With `REGFILE_WB_BYPASS_EN`, a lone load issues with latency 1.
